// File: rtl/serial_tx.sv
// Asynchronous serial transmitter: start bit, DATA_W data bits LSB first, optional
// even parity, one stop bit. Every output is a register, so the serial line never glitches.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_MAX = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     clk_cnt, clk_cnt_nxt;
    logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
    logic [DATA_W-1:0] shift, shift_nxt;
    logic              parity, parity_nxt;
    logic              tx_out_nxt, tx_ready_nxt, busy_nxt;
    logic              bit_done;

    assign bit_done = (clk_cnt == CNT_MAX);

    // Each branch computes the value the line must carry in the *next* cycle,
    // which is what lets tx_out come straight from a flop.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_nxt   = state;
        clk_cnt_nxt = clk_cnt;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        parity_nxt  = parity;
        tx_out_nxt  = tx_out;

        case (state)
            IDLE: begin
                tx_out_nxt = 1'b1;
                if (tx_valid && tx_ready) begin
                    state_nxt   = START;
                    shift_nxt   = tx_data;
                    parity_nxt  = ^tx_data;
                    clk_cnt_nxt = '0;
                    bit_cnt_nxt = '0;
                    tx_out_nxt  = 1'b0;
                end
            end

            START: begin
                if (bit_done) begin
                    state_nxt   = DATA;
                    clk_cnt_nxt = '0;
                    tx_out_nxt  = shift[0];
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end

            DATA: begin
                if (bit_done) begin
                    clk_cnt_nxt = '0;
                    shift_nxt   = shift >> 1;
                    if (bit_cnt == BIT_MAX) begin
                        bit_cnt_nxt = '0;
                        if (PARITY_EN != 0) begin
                            state_nxt  = PARITY;
                            tx_out_nxt = parity;
                        end else begin
                            state_nxt  = STOP;
                            tx_out_nxt = 1'b1;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        tx_out_nxt  = shift[1];
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end

            PARITY: begin
                if (bit_done) begin
                    state_nxt   = STOP;
                    clk_cnt_nxt = '0;
                    tx_out_nxt  = 1'b1;
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end

            STOP: begin
                if (bit_done) begin
                    state_nxt   = IDLE;
                    clk_cnt_nxt = '0;
                    shift_nxt   = '0;
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
                tx_out_nxt = 1'b1;
            end

            default: begin
                state_nxt   = IDLE;
                clk_cnt_nxt = '0;
                bit_cnt_nxt = '0;
                tx_out_nxt  = 1'b1;
            end
        endcase

        tx_ready_nxt = (state_nxt == IDLE);
        busy_nxt     = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            parity   <= 1'b0;
            tx_out   <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state    <= state_nxt;
            clk_cnt  <= clk_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shift    <= shift_nxt;
            parity   <= parity_nxt;
            tx_out   <= tx_out_nxt;
            tx_ready <= tx_ready_nxt;
            busy     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: one default instance and one with parity enabled,
// frames sampled cycle by cycle on the falling edge against hand-derived bit patterns.
module tb_serial_tx;

    localparam int N = 16;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       valid;
    logic       use_p;
    int         cyc;
    int         tests;
    int         fails;

    logic tx_valid_d, tx_ready_d, tx_out_d, busy_d;
    logic tx_valid_p, tx_ready_p, tx_out_p, busy_p;
    logic line, bsy, rdy;

    assign tx_valid_d = valid & ~use_p;
    assign tx_valid_p = valid & use_p;
    assign line = use_p ? tx_out_p   : tx_out_d;
    assign bsy  = use_p ? busy_p     : busy_d;
    assign rdy  = use_p ? tx_ready_p : tx_ready_d;

    serial_tx u_dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (data_in),
        .tx_valid (tx_valid_d),
        .tx_ready (tx_ready_d),
        .tx_out   (tx_out_d),
        .busy     (busy_d)
    );

    serial_tx #(.PARITY_EN(1)) u_dut_p (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (data_in),
        .tx_valid (tx_valid_p),
        .tx_ready (tx_ready_p),
        .tx_out   (tx_out_p),
        .busy     (busy_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_out"},   {31'd0, line}, 32'd1);
        check({tag, "_ready"}, {31'd0, rdy},  32'd1);
        check({tag, "_busy"},  {31'd0, bsy},  32'd0);
    endtask

    // Call at the falling edge where valid was raised; the next rising edge is the
    // accept edge and sampling starts on the following falling edge (cycle 0).
    task automatic capture(input logic [7:0] d, input logic par_en, input logic par,
                           input logic hold, input logic [7:0] next_d, input logic scramble,
                           input string tag, output int start_cyc);
        int   nfb;
        int   errs;
        logic exp_bit;
        logic first;
        nfb = 10 + (par_en ? 1 : 0);
        start_cyc = 0;
        for (int b = 0; b < nfb; b++) begin
            if (b == 0)
                exp_bit = 1'b0;
            else if (b <= 8)
                exp_bit = d[b-1];
            else if (par_en && b == 9)
                exp_bit = par;
            else
                exp_bit = 1'b1;
            errs  = 0;
            first = 1'bx;
            for (int k = 0; k < N; k++) begin
                @(negedge clk);
                if (b == 0 && k == 0) begin
                    start_cyc = cyc;
                    if (!hold) valid = 1'b0;
                    data_in = next_d;
                end
                if (scramble) data_in = 8'($urandom);
                if (k == 0) first = line;
                if (line !== exp_bit) errs++;
                if (bsy !== 1'b1) errs++;
                if (rdy !== 1'b0) errs++;
            end
            check($sformatf("%s_bit%0d", tag, b), {31'd0, first}, {31'd0, exp_bit});
            check($sformatf("%s_bit%0d_steady", tag, b), errs, 32'd0);
        end
    endtask

    initial begin
        int s0, s1, s2;
        tests   = 0;
        fails   = 0;
        rst     = 1'b1;
        valid   = 1'b0;
        data_in = 8'h00;
        use_p   = 1'b0;

        repeat (3) begin
            @(negedge clk);
            check_idle("reset");
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_idle("idle_no_valid");
        end

        // 0xA5 -> 0,1,0,1,0,0,1,0,1,1
        valid   = 1'b1;
        data_in = 8'hA5;
        capture(8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, "a5", s0);
        @(negedge clk);
        check_idle("a5_end");

        // 0x07 with parity: three ones -> parity bit 1, 11 bits = 176 cycles
        use_p   = 1'b1;
        valid   = 1'b1;
        data_in = 8'h07;
        capture(8'h07, 1'b1, 1'b1, 1'b0, 8'h07, 1'b0, "p07", s0);
        @(negedge clk);
        check_idle("p07_end");
        use_p = 1'b0;

        // back-to-back 0x00 then 0xFF with valid held high
        valid   = 1'b1;
        data_in = 8'h00;
        capture(8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, "b2b0", s1);
        @(negedge clk);
        check_idle("b2b_gap");
        capture(8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, "b2b1", s2);
        check("b2b_period", s2 - s1, 32'd161);
        @(negedge clk);
        check_idle("b2b_end");

        // payload input churns every cycle after accept
        valid   = 1'b1;
        data_in = 8'h3C;
        capture(8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, "scr3c", s0);
        @(negedge clk);
        check_idle("scr3c_end");

        // reset during data bit 3 of 0x52 (bit 3 = 0); frame bit 4 spans cycles 64..79
        valid   = 1'b1;
        data_in = 8'h52;
        for (int c = 0; c < 69; c++) begin
            @(negedge clk);
            if (c == 0) valid = 1'b0;
        end
        check("mid_bit3_out",  {31'd0, line}, 32'd0);
        check("mid_bit3_busy", {31'd0, bsy},  32'd1);
        #2 rst = 1'b1;
        #1 check_idle("async_rst");
        repeat (2) begin
            @(negedge clk);
            check_idle("rst_hold");
        end
        rst     = 1'b0;
        valid   = 1'b1;
        data_in = 8'h96;
        capture(8'h96, 1'b0, 1'b0, 1'b0, 8'h96, 1'b0, "post_rst", s0);
        @(negedge clk);
        check_idle("post_rst_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
